ghost_chaser: RTL and testbench

Movement controller for one ghost. Replaces the fixed ghost-coordinate registers and drives the ghost position directly into the display stage.
Each movement step it picks a direction that closes on Pac-Man. It checks that direction against the maze through a valid/ready wall-query port, moves one pixel, and flags a catch.
It sits upstream of the display block and alongside the Pac-Man key controller, whose position it consumes.

---
 rtl/pacman_pkg.sv | 27 ++
 rtl/ghost_dir_pick.sv | 40 ++++
 rtl/ghost_chaser.sv | 222 ++++++++++++++++++++++
 tb/tb_ghost_chaser.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared definitions for the Pac-Man game blocks: move directions,
// screen bounds and the ghost movement FSM state encoding.
package pacman_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_QUERY,
        ST_MOVE,
        ST_CHECK,
        ST_CAUGHT
    } ghost_state_t;

    // Up/down and left/right differ only in bit 0 of the encoding.
    function automatic logic [1:0] opposite_dir(input logic [1:0] dir);
        return dir ^ 2'b01;
    endfunction

endpackage

// File: rtl/ghost_dir_pick.sv
// Combinational direction chooser: ranks the four moves from the ghost
// toward a target point. cands_o[1:0] is tried first, cands_o[7:6] last.
module ghost_dir_pick
    import pacman_pkg::*;
(
    input  logic [9:0] ghost_x_i,
    input  logic [8:0] ghost_y_i,
    input  logic [9:0] tgt_x_i,
    input  logic [9:0] tgt_y_i,
    output logic [7:0] cands_o
);

    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic [10:0]        adx;
    logic [10:0]        ady;
    logic [1:0]         toward_x;
    logic [1:0]         toward_y;
    logic [1:0]         c0;
    logic [1:0]         c1;

    // Larger distance picks the primary axis; a zero offset counts as "toward positive".
    always_comb begin
        dx       = $signed({1'b0, tgt_x_i}) - $signed({1'b0, ghost_x_i});
        dy       = $signed({1'b0, tgt_y_i}) - $signed({2'b00, ghost_y_i});
        adx      = dx[10] ? $unsigned(-dx) : $unsigned(dx);
        ady      = dy[10] ? $unsigned(-dy) : $unsigned(dy);
        toward_x = dx[10] ? DIR_LEFT : DIR_RIGHT;
        toward_y = dy[10] ? DIR_UP   : DIR_DOWN;
        if (adx >= ady) begin
            c0 = toward_x;
            c1 = toward_y;
        end else begin
            c0 = toward_y;
            c1 = toward_x;
        end
        cands_o = {opposite_dir(c0), opposite_dir(c1), c1, c0};
    end

endmodule

// File: rtl/ghost_chaser.sv
// Ghost movement controller. Every STEP_DIV cycles it ranks four moves
// toward Pac-Man, asks the maze about each in turn over a valid/ready
// wall-query port, takes the first free one and checks for a catch.
// Optional build macro GHOST_SCATTER_EN: alternates 64 chase steps with
// 16 scatter steps aimed at the top-right corner.
module ghost_chaser
    import pacman_pkg::*;
#(
    parameter int STEP_DIV   = 500000,
    parameter int START_X    = 200,
    parameter int START_Y    = 146,
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479,
    parameter int CATCH_DIST = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       en,
    input  logic [9:0] pac_x,
    input  logic [9:0] pac_y,
    output logic       wall_valid,
    output logic [9:0] wall_x,
    output logic [8:0] wall_y,
    input  logic       wall_ready,
    input  logic       wall_blocked,
    output logic [9:0] ghost_x,
    output logic [8:0] ghost_y,
    output logic [1:0] ghost_dir,
    output logic       caught
);

    localparam int              CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    ghost_state_t     state_q;
    logic [CNT_W-1:0] step_cnt_q;
    logic [7:0]       cands_q;
    logic [1:0]       idx_q;
    logic [9:0]       ghost_x_q;
    logic [8:0]       ghost_y_q;
    logic [1:0]       dir_q;
    logic             caught_q;
    logic             wall_valid_q;
    logic [9:0]       wall_x_q;
    logic [8:0]       wall_y_q;
    logic             pend_q;
    logic             pend_blk_q;

    logic             step_pulse;
    logic             scatter;
    logic [9:0]       pick_tx;
    logic [9:0]       pick_ty;
    logic [7:0]       pick_cands;
    logic [1:0]       cur_dir;
    logic [9:0]       tgt_x_d;
    logic [8:0]       tgt_y_d;
    logic             tgt_oob;
    logic             q_resolve;
    logic             q_blk;
    logic signed [10:0] cdx;
    logic signed [10:0] cdy;
    logic [10:0]      acdx;
    logic [10:0]      acdy;
    logic             near;

    assign step_pulse = en && (state_q == ST_IDLE) && (step_cnt_q == CNT_LAST);

`ifdef GHOST_SCATTER_EN
    logic [6:0] mode_cnt_q;

    // Step-mode counter: 0..63 chase, 64..79 scatter; advances as each PICK completes.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mode_cnt_q <= 7'd0;
        end else if (en && state_q == ST_PICK) begin
            mode_cnt_q <= (mode_cnt_q == 7'd79) ? 7'd0 : mode_cnt_q + 7'd1;
        end
    end

    assign scatter = (mode_cnt_q >= 7'd64);
`else
    assign scatter = 1'b0;
`endif

    assign pick_tx = scatter ? 10'(X_MAX) : pac_x;
    assign pick_ty = scatter ? 10'd0      : pac_y;

    ghost_dir_pick u_pick (
        .ghost_x_i (ghost_x_q),
        .ghost_y_i (ghost_y_q),
        .tgt_x_i   (pick_tx),
        .tgt_y_i   (pick_ty),
        .cands_o   (pick_cands)
    );

    // Candidate under test and the pixel one step away in that direction.
    always_comb begin
        case (idx_q)
            2'd0:    cur_dir = cands_q[1:0];
            2'd1:    cur_dir = cands_q[3:2];
            2'd2:    cur_dir = cands_q[5:4];
            default: cur_dir = cands_q[7:6];
        endcase
        tgt_x_d = ghost_x_q;
        tgt_y_d = ghost_y_q;
        tgt_oob = 1'b0;
        case (cur_dir)
            DIR_UP: begin
                if (ghost_y_q == 9'd0) tgt_oob = 1'b1;
                else                   tgt_y_d = ghost_y_q - 9'd1;
            end
            DIR_DOWN: begin
                if (ghost_y_q == 9'(Y_MAX)) tgt_oob = 1'b1;
                else                        tgt_y_d = ghost_y_q + 9'd1;
            end
            DIR_LEFT: begin
                if (ghost_x_q == 10'd0) tgt_oob = 1'b1;
                else                    tgt_x_d = ghost_x_q - 10'd1;
            end
            default: begin
                if (ghost_x_q == 10'(X_MAX)) tgt_oob = 1'b1;
                else                         tgt_x_d = ghost_x_q + 10'd1;
            end
        endcase
    end

    // A query resolves from a result latched while frozen, a live handshake, or an off-screen target.
    always_comb begin
        q_resolve = pend_q || (wall_valid_q && wall_ready) || (!wall_valid_q && tgt_oob);
        if (pend_q)            q_blk = pend_blk_q;
        else if (wall_valid_q) q_blk = wall_blocked;
        else                   q_blk = 1'b1;
    end

    // Catch window around Pac-Man, evaluated on the freshly moved position.
    always_comb begin
        cdx  = $signed({1'b0, pac_x}) - $signed({1'b0, ghost_x_q});
        cdy  = $signed({1'b0, pac_y}) - $signed({2'b00, ghost_y_q});
        acdx = cdx[10] ? $unsigned(-cdx) : $unsigned(cdx);
        acdy = cdy[10] ? $unsigned(-cdy) : $unsigned(cdy);
        near = (acdx <= 11'(CATCH_DIST)) && (acdy <= 11'(CATCH_DIST));
    end

    // Movement FSM with step counter, wall-query handshake and registered outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= ST_IDLE;
            step_cnt_q   <= '0;
            cands_q      <= 8'd0;
            idx_q        <= 2'd0;
            ghost_x_q    <= 10'(START_X);
            ghost_y_q    <= 9'(START_Y);
            dir_q        <= DIR_RIGHT;
            caught_q     <= 1'b0;
            wall_valid_q <= 1'b0;
            wall_x_q     <= 10'd0;
            wall_y_q     <= 9'd0;
            pend_q       <= 1'b0;
            pend_blk_q   <= 1'b0;
        end else if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (step_pulse) begin
                        step_cnt_q <= '0;
                        state_q    <= ST_PICK;
                    end else begin
                        step_cnt_q <= step_cnt_q + 1'b1;
                    end
                end
                ST_PICK: begin
                    cands_q <= pick_cands;
                    idx_q   <= 2'd0;
                    state_q <= ST_QUERY;
                end
                ST_QUERY: begin
                    if (q_resolve) begin
                        pend_q       <= 1'b0;
                        wall_valid_q <= 1'b0;
                        if (!q_blk)             state_q <= ST_MOVE;
                        else if (idx_q == 2'd3) state_q <= ST_IDLE;
                        else                    idx_q   <= idx_q + 2'd1;
                    end else if (!wall_valid_q) begin
                        wall_valid_q <= 1'b1;
                        wall_x_q     <= tgt_x_d;
                        wall_y_q     <= tgt_y_d;
                    end
                end
                ST_MOVE: begin
                    ghost_x_q <= tgt_x_d;
                    ghost_y_q <= tgt_y_d;
                    dir_q     <= cur_dir;
                    state_q   <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (near) begin
                        caught_q <= 1'b1;
                        state_q  <= ST_CAUGHT;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_CAUGHT;
                end
            endcase
        end else if (wall_valid_q && wall_ready) begin
            // Frozen, but the maze took the query: keep its answer for when en returns.
            wall_valid_q <= 1'b0;
            pend_q       <= 1'b1;
            pend_blk_q   <= wall_blocked;
        end
    end

    assign wall_valid = wall_valid_q;
    assign wall_x     = wall_x_q;
    assign wall_y     = wall_y_q;
    assign ghost_x    = ghost_x_q;
    assign ghost_y    = ghost_y_q;
    assign ghost_dir  = dir_q;
    assign caught     = caught_q;

endmodule

// File: tb/tb_ghost_chaser.sv
// Directed bench for ghost_chaser with a fast step divider and a
// programmable maze model on the wall-query port.
module tb_ghost_chaser;

    logic       clk = 1'b0;
    logic       clrn;
    logic       en;
    logic [9:0] pac_x;
    logic [9:0] pac_y;
    logic       wall_valid;
    logic [9:0] wall_x;
    logic [8:0] wall_y;
    logic       wall_ready;
    logic       wall_blocked;
    logic [9:0] ghost_x;
    logic [8:0] ghost_y;
    logic [1:0] ghost_dir;
    logic       caught;

    logic       blk_all;
    logic       blk_one;
    logic [9:0] blk_x;
    logic [8:0] blk_y;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          hs_cnt   = 0;
    logic [18:0] hs_log[$];

    always #5 clk = ~clk;

    assign wall_blocked = blk_all | (blk_one & (wall_x == blk_x) & (wall_y == blk_y));

    ghost_chaser #(.STEP_DIV(4)) dut (
        .clk          (clk),
        .clrn         (clrn),
        .en           (en),
        .pac_x        (pac_x),
        .pac_y        (pac_y),
        .wall_valid   (wall_valid),
        .wall_x       (wall_x),
        .wall_y       (wall_y),
        .wall_ready   (wall_ready),
        .wall_blocked (wall_blocked),
        .ghost_x      (ghost_x),
        .ghost_y      (ghost_y),
        .ghost_dir    (ghost_dir),
        .caught       (caught)
    );

    // Record every accepted wall query.
    always @(posedge clk) begin
        if (clrn && wall_valid && wall_ready) begin
            hs_cnt <= hs_cnt + 1;
            hs_log.push_back({wall_x, wall_y});
        end
    end

    task automatic apply_reset();
        en         = 1'b0;
        wall_ready = 1'b0;
        blk_all    = 1'b0;
        blk_one    = 1'b0;
        blk_x      = 10'd0;
        blk_y      = 9'd0;
        pac_x      = 10'd300;
        pac_y      = 10'd146;
        clrn       = 1'b0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int t;
        apply_reset();
        n_checks++; if (ghost_x !== 10'd200) begin n_fail++; $display("FAIL rst_ghost_x got %0d want 200", ghost_x); end
        n_checks++; if (ghost_y !== 9'd146) begin n_fail++; $display("FAIL rst_ghost_y got %0d want 146", ghost_y); end
        n_checks++; if (ghost_dir !== 2'd3) begin n_fail++; $display("FAIL rst_dir got %0d want 3", ghost_dir); end
        n_checks++; if (caught !== 1'b0) begin n_fail++; $display("FAIL rst_caught got %0b want 0", caught); end
        n_checks++; if (wall_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wall_valid got %0b want 0", wall_valid); end
        n_checks++; if ({wall_x, wall_y} !== 19'd0) begin n_fail++; $display("FAIL rst_wall_xy got %0d,%0d want 0,0", wall_x, wall_y); end
        // Asynchronous reset while a query is outstanding.
        en = 1'b1;
        t  = 0;
        while (wall_valid !== 1'b1 && t < 30) begin @(negedge clk); t++; end
        n_checks++; if (wall_valid !== 1'b1) begin n_fail++; $display("FAIL rst_query_start got %0b want 1", wall_valid); end
        #2 clrn = 1'b0;
        #1;
        n_checks++; if (wall_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got %0b want 0", wall_valid); end
        n_checks++; if (wall_x !== 10'd0) begin n_fail++; $display("FAIL async_rst_wall_x got %0d want 0", wall_x); end
        @(negedge clk);
    endtask

    task automatic test_open_maze();
        int base;
        int t;
        apply_reset();
        wall_ready = 1'b1;
        base       = hs_cnt;
        en         = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            t = 0;
            while (ghost_x !== 10'(200 + k) && t < 40) begin @(negedge clk); t++; end
            n_checks++; if (ghost_x !== 10'(200 + k)) begin n_fail++; $display("FAIL open_step_x got %0d want %0d", ghost_x, 200 + k); end
            n_checks++; if (hs_cnt - base !== k) begin n_fail++; $display("FAIL open_queries got %0d want %0d", hs_cnt - base, k); end
            repeat (3) begin
                @(negedge clk);
                n_checks++; if (ghost_x !== 10'(200 + k)) begin n_fail++; $display("FAIL open_hold_x got %0d want %0d", ghost_x, 200 + k); end
            end
        end
        n_checks++; if (ghost_y !== 9'd146) begin n_fail++; $display("FAIL open_y got %0d want 146", ghost_y); end
        n_checks++; if (ghost_dir !== 2'd3) begin n_fail++; $display("FAIL open_dir got %0d want 3", ghost_dir); end
        en = 1'b0;
    endtask

    task automatic test_blocked_primary();
        int base;
        int t;
        apply_reset();
        blk_one    = 1'b1;
        blk_x      = 10'd201;
        blk_y      = 9'd146;
        wall_ready = 1'b1;
        base       = hs_log.size();
        en         = 1'b1;
        t = 0;
        while (ghost_x === 10'd200 && ghost_y === 9'd146 && t < 40) begin @(negedge clk); t++; end
        en = 1'b0;
        n_checks++; if ({ghost_x, ghost_y} !== {10'd200, 9'd147}) begin n_fail++; $display("FAIL blk_pos got %0d,%0d want 200,147", ghost_x, ghost_y); end
        n_checks++; if (ghost_dir !== 2'd1) begin n_fail++; $display("FAIL blk_dir got %0d want 1", ghost_dir); end
        n_checks++; if (hs_log.size() - base !== 2) begin n_fail++; $display("FAIL blk_queries got %0d want 2", hs_log.size() - base); end
        if (hs_log.size() >= base + 2) begin
            n_checks++; if (hs_log[base] !== {10'd201, 9'd146}) begin n_fail++; $display("FAIL blk_first_query got %0d,%0d want 201,146", hs_log[base][18:9], hs_log[base][8:0]); end
            n_checks++; if (hs_log[base+1] !== {10'd200, 9'd147}) begin n_fail++; $display("FAIL blk_second_query got %0d,%0d want 200,147", hs_log[base+1][18:9], hs_log[base+1][8:0]); end
        end
    endtask

    task automatic test_backpressure();
        int t;
        apply_reset();
        en = 1'b1;
        t  = 0;
        while (wall_valid !== 1'b1 && t < 30) begin @(negedge clk); t++; end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (wall_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held got %0b want 1", wall_valid); end
            n_checks++; if ({wall_x, wall_y} !== {10'd201, 9'd146}) begin n_fail++; $display("FAIL bp_addr_stable got %0d,%0d want 201,146", wall_x, wall_y); end
            @(negedge clk);
        end
        wall_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (wall_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop got %0b want 0", wall_valid); end
        n_checks++; if (ghost_x !== 10'd200) begin n_fail++; $display("FAIL bp_move_cycle_x got %0d want 200", ghost_x); end
        @(negedge clk);
        n_checks++; if (ghost_x !== 10'd201) begin n_fail++; $display("FAIL bp_moved_x got %0d want 201", ghost_x); end
        en = 1'b0;
    endtask

    task automatic test_all_blocked();
        int base;
        int t;
        apply_reset();
        blk_all    = 1'b1;
        wall_ready = 1'b1;
        base       = hs_cnt;
        en         = 1'b1;
        t = 0;
        while (hs_cnt - base < 4 && t < 60) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        n_checks++; if (hs_cnt - base !== 4) begin n_fail++; $display("FAIL allblk_queries got %0d want 4", hs_cnt - base); end
        n_checks++; if (wall_valid !== 1'b0) begin n_fail++; $display("FAIL allblk_idle_valid got %0b want 0", wall_valid); end
        n_checks++; if ({ghost_x, ghost_y} !== {10'd200, 9'd146}) begin n_fail++; $display("FAIL allblk_pos got %0d,%0d want 200,146", ghost_x, ghost_y); end
        n_checks++; if (ghost_dir !== 2'd3) begin n_fail++; $display("FAIL allblk_dir got %0d want 3", ghost_dir); end
        t = 0;
        while (hs_cnt - base < 8 && t < 60) begin @(negedge clk); t++; end
        n_checks++; if (hs_cnt - base !== 8) begin n_fail++; $display("FAIL allblk_retry got %0d want 8", hs_cnt - base); end
        n_checks++; if ({ghost_x, ghost_y} !== {10'd200, 9'd146}) begin n_fail++; $display("FAIL allblk_retry_pos got %0d,%0d want 200,146", ghost_x, ghost_y); end
        en = 1'b0;
    endtask

    task automatic test_catch();
        int t;
        int base;
        int bad;
        apply_reset();
        pac_x      = 10'd205;
        pac_y      = 10'd150;
        wall_ready = 1'b1;
        en         = 1'b1;
        t = 0;
        while (caught !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        n_checks++; if (caught !== 1'b1) begin n_fail++; $display("FAIL catch_flag got %0b want 1", caught); end
        n_checks++; if ({ghost_x, ghost_y} !== {10'd201, 9'd146}) begin n_fail++; $display("FAIL catch_pos got %0d,%0d want 201,146", ghost_x, ghost_y); end
        base = hs_cnt;
        bad  = 0;
        repeat (30) begin
            @(negedge clk);
            if (wall_valid !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL catch_no_query got %0d cycles want 0", bad); end
        n_checks++; if (hs_cnt !== base) begin n_fail++; $display("FAIL catch_no_handshake got %0d want %0d", hs_cnt, base); end
        n_checks++; if ({ghost_x, ghost_y} !== {10'd201, 9'd146}) begin n_fail++; $display("FAIL catch_frozen got %0d,%0d want 201,146", ghost_x, ghost_y); end
        n_checks++; if (caught !== 1'b1) begin n_fail++; $display("FAIL catch_sticky got %0b want 1", caught); end
        #2 clrn = 1'b0;
        #1;
        n_checks++; if (caught !== 1'b0) begin n_fail++; $display("FAIL catch_cleared got %0b want 0", caught); end
        n_checks++; if (ghost_x !== 10'd200) begin n_fail++; $display("FAIL catch_rst_x got %0d want 200", ghost_x); end
        @(negedge clk);
        clrn = 1'b1;
        en   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_open_maze();
        test_blocked_primary();
        test_backpressure();
        test_all_blocked();
        test_catch();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", n_checks);
        $fatal(1, "timeout");
    end

endmodule
